// File: rtl/bcd_dec_pkg.sv
// ---------------------------------------------------------------------------
// bcd_dec_pkg
// Shared constants and types for the BCD scan decoder slice.
//   ONEHOT_W : width of a one-hot decimal decode (digits 0..9)
//   BCD_MAX  : largest legal BCD code
//   state_t  : scan FSM state (IDLE = nothing loaded, SCAN = frame running)
// ---------------------------------------------------------------------------
package bcd_dec_pkg;

  localparam int         ONEHOT_W = 10;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_decoder_if
// Load handshake and display bus of the BCD scan decoder.
//   in_valid  : source has a packed BCD word on in_bcd
//   in_ready  : decoder can take a word this cycle
//   in_bcd    : packed BCD word, digit 0 in bits [3:0]
//   err_clr   : clears the sticky invalid-code flag
//   dig_sel   : one-hot active digit (all zero when idle)
//   dec_out   : one-hot decimal decode of the active digit
//   err       : sticky flag, a loaded word held a code above 9
//   scan_wrap : pulse on the last cycle of every frame
// Modports: master = word source / display consumer, slave = decoder.
// ---------------------------------------------------------------------------
interface bcd_scan_decoder_if
  import bcd_dec_pkg::*;
#(
  parameter int DIGITS = 4
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [4*DIGITS-1:0]     in_bcd;
  logic                    err_clr;
  logic [DIGITS-1:0]       dig_sel;
  logic [ONEHOT_W-1:0]     dec_out;
  logic                    err;
  logic                    scan_wrap;

  modport master (
    output in_valid, in_bcd, err_clr,
    input  in_ready, dig_sel, dec_out, err, scan_wrap
  );

  modport slave (
    input  in_valid, in_bcd, err_clr,
    output in_ready, dig_sel, dec_out, err, scan_wrap
  );

endinterface

// File: rtl/bcd_onehot_dec.sv
// ---------------------------------------------------------------------------
// bcd_onehot_dec
// Combinational 8421 BCD to 10-line one-hot decoder.
//   i_bcd     : 4-bit BCD code
//   o_onehot  : bit n set for code n; all zero for codes 10..15
//   o_invalid : high for codes 10..15
// ---------------------------------------------------------------------------
module bcd_onehot_dec
  import bcd_dec_pkg::*;
(
  input  logic [3:0]          i_bcd,
  output logic [ONEHOT_W-1:0] o_onehot,
  output logic                o_invalid
);

  // Codes above 9 have no decimal line, so they decode to an empty vector.
  always_comb begin
    o_invalid = (i_bcd > BCD_MAX);
    o_onehot  = '0;
    if (!o_invalid) begin
      o_onehot = ONEHOT_W'(1) << i_bcd;
    end
  end

endmodule

// File: rtl/bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// bcd_scan_decoder
// Holds a DIGITS-wide packed BCD word and scans it one digit at a time,
// showing each digit for SCAN_DIV cycles. New words are only taken at a
// frame boundary so the display never shows a mix of two words.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_scan_decoder_if.slave (load handshake + display outputs)
// Parameters: DIGITS (>= 2), SCAN_DIV (>= 1).
// Optional build macro: LEADING_ZERO_BLANK_EN - blank digits above the most
// significant non-zero digit (digit 0 always shown).
// ---------------------------------------------------------------------------
module bcd_scan_decoder
  import bcd_dec_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_scan_decoder_if.slave     bus
);

  localparam int               W_WORD  = 4 * DIGITS;
  localparam int               DI_W    = $clog2(DIGITS);
  localparam int               PC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DI_W-1:0]  DI_LAST = DI_W'(DIGITS - 1);
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(SCAN_DIV - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [PC_W-1:0]       r_pc;
  logic [PC_W-1:0]       w_next_pc;
  logic [DI_W-1:0]       r_di;
  logic [DI_W-1:0]       w_next_di;
  logic [W_WORD-1:0]     r_word;
  logic [W_WORD-1:0]     w_next_word;
  logic [DIGITS-1:0]     r_dig_sel;
  logic [DIGITS-1:0]     w_next_sel;
  logic [ONEHOT_W-1:0]   r_dec_out;
  logic [ONEHOT_W-1:0]   w_next_dec;
  logic                  r_err;
  logic                  w_frame_end;
  logic                  w_ready;
  logic                  w_accept;
  logic [3:0]            w_next_code;
  logic [ONEHOT_W-1:0]   w_next_onehot;
  logic                  w_next_invalid;
  logic [DIGITS-1:0]     w_in_invalid;
  logic                  w_next_blanked;

`ifdef LEADING_ZERO_BLANK_EN
  logic [ONEHOT_W-1:0]   w_in_onehot [DIGITS];
  logic [DIGITS-1:0]     w_in_blank;
  logic [DIGITS-1:0]     w_next_blank;
  logic [DIGITS-1:0]     r_blank;
`endif

  // One decoder per incoming digit, used at load time to spot invalid codes
  // (and zero digits for leading-zero blanking).
  for (genvar g = 0; g < DIGITS; g++) begin : gen_in_dec
    bcd_onehot_dec u_in_dec (
      .i_bcd     (bus.in_bcd[4*g +: 4]),
`ifdef LEADING_ZERO_BLANK_EN
      .o_onehot  (w_in_onehot[g]),
`else
      .o_onehot  (),
`endif
      .o_invalid (w_in_invalid[g])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit: a digit is blanked while every digit from
  // it upwards is zero. Digit 0 is excluded so a zero word still shows "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    w_in_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (w_in_onehot[i] == ONEHOT_W'(1));
      w_in_blank[i] = upper_zero;
    end
  end
`endif

  // Frame boundary and handshake. Ready is purely a function of the scan
  // position so a source can never create a combinational loop through it.
  always_comb begin
    w_frame_end = (r_di == DI_LAST) && (r_pc == PC_LAST);
    w_ready     = (r_state == IDLE) || w_frame_end;
    w_accept    = bus.in_valid && w_ready;
  end

  // Next-state logic for the FSM, scan counters and holding register. An
  // accepted load restarts the frame at digit 0; otherwise the prescaler
  // runs and the digit index steps each time the prescaler wraps.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_di    = r_di;
    w_next_word  = r_word;

    case (r_state)
      IDLE:    if (w_accept) w_next_state = SCAN;
      SCAN:    w_next_state = SCAN;
      default: w_next_state = IDLE;
    endcase

    if (w_accept) begin
      w_next_pc   = '0;
      w_next_di   = '0;
      w_next_word = bus.in_bcd;
    end else if (r_state == SCAN) begin
      if (r_pc == PC_LAST) begin
        w_next_pc = '0;
        w_next_di = (r_di == DI_LAST) ? '0 : r_di + 1'b1;
      end else begin
        w_next_pc = r_pc + 1'b1;
      end
    end
  end

  // The display outputs are registered, so they are computed from the
  // *next* word and digit index; this keeps dig_sel/dec_out aligned with
  // the counters and lets a fresh word appear the cycle after it is taken.
  always_comb begin
    w_next_code    = '0;
    w_next_sel     = '0;
    w_next_blanked = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    w_next_blank   = w_accept ? w_in_blank : r_blank;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (w_next_di == DI_W'(i)) begin
        w_next_code   = w_next_word[4*i +: 4];
        w_next_sel[i] = (w_next_state == SCAN);
`ifdef LEADING_ZERO_BLANK_EN
        w_next_blanked = w_next_blank[i];
`endif
      end
    end
  end

  bcd_onehot_dec u_disp_dec (
    .i_bcd     (w_next_code),
    .o_onehot  (w_next_onehot),
    .o_invalid (w_next_invalid)
  );

  // Nothing is lit while idle; blanked or invalid digits keep their select
  // line but show an empty decode.
  always_comb begin
    w_next_dec = '0;
    if ((w_next_state == SCAN) && !w_next_invalid && !w_next_blanked) begin
      w_next_dec = w_next_onehot;
    end
  end

  // State, counters, held word and display registers. Reset discards the
  // held word and returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_di      <= '0;
      r_word    <= '0;
      r_dig_sel <= '0;
      r_dec_out <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank   <= '0;
`endif
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_di      <= w_next_di;
      r_word    <= w_next_word;
      r_dig_sel <= w_next_sel;
      r_dec_out <= w_next_dec;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank   <= w_next_blank;
`endif
    end
  end

  // Sticky error flag. Setting takes priority over a simultaneous clear so
  // a bad word loaded while software is clearing is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (|w_in_invalid)) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.dig_sel   = r_dig_sel;
  assign bus.dec_out   = r_dec_out;
  assign bus.err       = r_err;
  assign bus.scan_wrap = (r_state == SCAN) && w_frame_end;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_decoder
// Self-checking bench for bcd_scan_decoder (DIGITS=4, SCAN_DIV=2). A
// behavioural model tracks "word loaded", the position inside the frame and
// the sticky error, and derives every expected output from those.
// ---------------------------------------------------------------------------
module tb_bcd_scan_decoder;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bcd_scan_decoder_if #(.DIGITS(DIGITS)) busIf ();

  bcd_scan_decoder #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  // Reference model state
  bit          modelLoaded;
  int          modelPos;
  logic [15:0] modelWord;
  bit          modelErr;

  int vectorCount = 0;
  int missCount   = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  function automatic bit modelReady();
    return !modelLoaded || (modelPos == FRAME - 1);
  endfunction

  function automatic bit hasBadDigit(input logic [15:0] w);
    for (int d = 0; d < DIGITS; d++) begin
      if (((w >> (4 * d)) & 16'hF) > 16'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] expectedDigSel();
    if (!modelLoaded) return 32'd0;
    return 32'd1 << (modelPos / SCAN_DIV);
  endfunction

  function automatic logic [31:0] expectedDecode();
    int digit;
    int code;
    if (!modelLoaded) return 32'd0;
    digit = modelPos / SCAN_DIV;
    code  = int'((modelWord >> (4 * digit)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (digit > 0 && (modelWord >> (4 * digit)) == 16'd0) return 32'd0;
`endif
    if (code > 9) return 32'd0;
    return 32'd1 << code;
  endfunction

  task automatic modelReset();
    modelLoaded = 1'b0;
    modelPos    = 0;
    modelWord   = '0;
    modelErr    = 1'b0;
  endtask

  task automatic checkAllOutputs();
    checkOutput("in_ready",  32'(busIf.in_ready),  32'(modelReady()));
    checkOutput("dig_sel",   32'(busIf.dig_sel),   expectedDigSel());
    checkOutput("dec_out",   32'(busIf.dec_out),   expectedDecode());
    checkOutput("err",       32'(busIf.err),       32'(modelErr));
    checkOutput("scan_wrap", 32'(busIf.scan_wrap),
                32'(modelLoaded && (modelPos == FRAME - 1)));
  endtask

  // One clock cycle: check outputs mid-cycle, drive inputs, advance model.
  task automatic applyStimulus(input logic v, input logic [15:0] bcd,
                               input logic clr);
    bit accept;
    @(negedge clk);
    checkAllOutputs();
    busIf.in_valid = v;
    busIf.in_bcd   = bcd;
    busIf.err_clr  = clr;
    accept = v && modelReady();
    if (accept && hasBadDigit(bcd)) modelErr = 1'b1;
    else if (clr)                   modelErr = 1'b0;
    if (accept) begin
      modelWord   = bcd;
      modelLoaded = 1'b1;
      modelPos    = 0;
    end else if (modelLoaded) begin
      modelPos = (modelPos + 1) % FRAME;
    end
    @(posedge clk);
  endtask

  // Mid-cycle asynchronous reset: outputs must drop before any clock edge.
  task automatic asyncResetCheck();
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    busIf.in_valid = 1'b0;
    busIf.err_clr  = 1'b0;
    #1;
    modelReset();
    checkAllOutputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] randomWord();
    logic [15:0] w;
    int r;
    int k;
    w = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r = int'($urandom_range(0, 15));
      if (r < 13) w[4*d +: 4] = 4'(r % 10);
      else        w[4*d +: 4] = 4'($urandom_range(10, 15));
    end
    if ($urandom_range(0, 3) == 0) begin
      k = int'($urandom_range(0, 3));
      w = 16'(int'(w) & ((1 << (4 * k)) - 1));
    end
    return w;
  endfunction

  initial begin
    rst_n          = 1'b0;
    busIf.in_valid = 1'b0;
    busIf.in_bcd   = '0;
    busIf.err_clr  = 1'b0;
    modelReset();
    #1;
    checkAllOutputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b0);

    $display("[TB] load 1234, hold 5678 from mid-frame");
    applyStimulus(1'b1, 16'h1234, 1'b0);
    repeat (3)  applyStimulus(1'b0, 16'h0, 1'b0);
    repeat (8)  applyStimulus(1'b1, 16'h5678, 1'b0);
    repeat (10) applyStimulus(1'b0, 16'h0, 1'b0);

    $display("[TB] invalid codes and sticky error");
    repeat (FRAME) applyStimulus(1'b1, 16'h12F4, 1'b0);
    repeat (FRAME) applyStimulus(1'b1, 16'hA000, 1'b1);
    repeat (3)     applyStimulus(1'b0, 16'h0, 1'b0);
    repeat (FRAME) applyStimulus(1'b0, 16'h0, 1'b1);

    $display("[TB] leading zero words");
    repeat (FRAME + 1) applyStimulus(1'b1, 16'h0007, 1'b0);
    repeat (FRAME + 1) applyStimulus(1'b1, 16'h0000, 1'b0);
    repeat (FRAME + 1) applyStimulus(1'b1, 16'h0090, 1'b0);

    $display("[TB] asynchronous reset mid-frame");
    repeat (FRAME) applyStimulus(1'b1, 16'h1234, 1'b0);
    repeat (4)     applyStimulus(1'b0, 16'h0, 1'b0);
    asyncResetCheck();
    repeat (4)     applyStimulus(1'b0, 16'h0, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), randomWord(),
                    1'($urandom_range(0, 15) == 0));
    end
    applyStimulus(1'b0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount,
             missCount);
    $finish;
  end

endmodule

// File: doc/bcd_scan_decoder.md
# bcd_scan_decoder

Parametrised, registered successor to the 8421-to-10-line decoder. It holds a `DIGITS`-wide packed BCD word and time-multiplexes it one digit at a time. For each digit it drives a one-hot digit select and the 10-bit one-hot decode of that digit. New words are accepted only at frame boundaries through a valid/ready handshake, so the display never tears. Invalid codes (10–15) are flagged in a sticky error bit. The block sits between the BCD arithmetic/counter blocks and the multiplexed display/LED drivers.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits held and scanned; legal range ≥ 2.
- `SCAN_DIV`, 4: clock cycles each digit is shown; legal range ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_bcd` holds a word to load.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_bcd`  in  4*DIGITS  packed BCD; digit 0 = bits [3:0].
- `err_clr`  in  1  clears `err`.
- `dig_sel`  out  DIGITS  one-hot active digit; all zero in IDLE.
- `dec_out`  out  10  one-hot decode of the active digit: bit n set for value n.
- `err`  out  1  sticky flag: a loaded word contained a code > 9.
- `scan_wrap`  out  1  one-cycle pulse on the last cycle of every frame.

## Operation
- Two-state FSM:
  - IDLE: no word loaded.
  - SCAN: frame running.
- IDLE → SCAN on an accepted load (`in_valid && in_ready`). No transition back except by reset.
- Internal counters:
  - Prescaler `pc`: 0..SCAN_DIV-1.
  - Digit index `di`: 0..DIGITS-1.
  - In SCAN, `pc` increments every cycle. At SCAN_DIV-1 it wraps to 0 and `di` increments. `di` wraps DIGITS-1 → 0.
- `in_ready` is combinational: `state==IDLE || (di==DIGITS-1 && pc==SCAN_DIV-1)`. It never depends on `in_valid`.
- Accepted load:
  - Captures `in_bcd` into the holding register.
  - Forces `pc=0`, `di=0` for the next cycle.
- Frame end without a load: the old word is re-scanned from digit 0.
- A word presented while `in_ready=0` is ignored. The source must hold `in_valid` until ready.
- Decode rules:
  - Code 0..9 sets `dec_out` bit [code].
  - Code 10..15 gives `dec_out=0`.
  - `dig_sel` still asserts normally for an invalid digit.
- Error flag:
  - `err` is set the cycle after accepting a word with any digit > 9.
  - `err_clr` clears it.
  - If a set condition and `err_clr` occur in the same cycle, set wins.
- `scan_wrap` is high when in SCAN with `di==DIGITS-1` and `pc==SCAN_DIV-1`.

## Timing
- Reset values:
  - `dig_sel=0`, `dec_out=0`, `err=0`, `scan_wrap=0`.
  - `in_ready=1` (IDLE).
  - Holding register = 0, `pc=0`, `di=0`.
- `dig_sel` and `dec_out` are registered.
- Load accepted at edge k:
  - From cycle k+1: `dig_sel=1<<0` and `dec_out` = decode of digit 0.
  - Each digit is held exactly SCAN_DIV cycles.
  - Frame length is DIGITS*SCAN_DIV cycles.
- Back-to-back: a load accepted on the last cycle of a frame shows the new digit 0 on the very next cycle, with no gap.
- SCAN_DIV=1: digit advances every cycle, and `pc` is a constant 0.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous), the held word is discarded, and the block returns to IDLE. Deassertion is synchronised by the system reset controller.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - A digit above the most significant non-zero digit of the held word shows `dec_out=0`; `dig_sel` still cycles.
  - Digit 0 is never blanked.
  - The blank mask is computed at load time and registered alongside the word.
- Undefined: every digit is displayed, and zero decodes to 10'b0000000001.

## Structure
- Package `bcd_dec_pkg` holds:
  - `ONEHOT_W=10` and `BCD_MAX=4'd9`.
  - The FSM state typedef (IDLE, SCAN).
- One sub-module, `bcd_onehot_dec`: combinational 4 → 10 one-hot decode plus an `invalid` output.
  - One instance sits in the display path.
  - DIGITS instances sit on `in_bcd` for error and blank detection.
- Counters, FSM, holding register and output registers live in the top.

## Test plan
(DIGITS=4, SCAN_DIV=2 unless stated)
- Reset release, no load → `in_ready=1`, `dig_sel=0`, `dec_out=0` indefinitely.
- Load 16'h1234 at cycle 0:
  - Cycles 1–2: `dig_sel=0001`, `dec_out=10'b0000010000`.
  - Cycles 3–4: `0010`/`0000001000`.
  - Cycle 8: `scan_wrap=1`, `in_ready=1`.
  - Cycle 9: digit 0 again.
- Present 16'h5678 at cycle 4 and hold `in_valid` → ignored until cycle 8. From cycle 9, `dec_out=10'b0100000000` (digit 8).
- Load 16'h12F4 → `err=1` from the next cycle. The digit-1 slot shows `dec_out=0` with `dig_sel=0010`. `err_clr` together with a new invalid load keeps `err=1`.
- `rst_n` low during the digit-2 slot → all outputs go to reset values without waiting for a clock edge. After release the block is in IDLE and shows nothing.
- With `LEADING_ZERO_BLANK_EN`, load 16'h0007 → digits 3..1 show `dec_out=0`, digit 0 shows `10'b0010000000`. Load 16'h0000 → digit 0 shows `10'b0000000001`.
